// File: rtl/arb_mux_n.sv
// Packet-aware round-robin arbiter/mux: N flit channels share one registered
// output slot; a multi-flit packet keeps the output locked until its tail.
module arb_mux_n #(
  parameter int NUM_IN     = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NUM_IN-1:0]            valid_i,
  input  logic [NUM_IN-1:0]            head_i,
  input  logic [NUM_IN-1:0]            tail_i,
  input  logic [NUM_IN*DATA_WIDTH-1:0] data_i,
  output logic [NUM_IN-1:0]            ready_o,
  output logic [NUM_IN-1:0]            grant_o,
  output logic                         valid_o,
  output logic                         head_o,
  output logic                         tail_o,
  output logic [DATA_WIDTH-1:0]        data_o,
  input  logic                         ready_i
);

  localparam int IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                state;
  logic [IW-1:0]         lock_idx;
  logic [IW-1:0]         last_idx;
  logic [IW-1:0]         gnt_idx;
  logic [IW-1:0]         scan_idx;
  logic [NUM_IN-1:0]     cand;
  logic                  found;
  logic                  slot_free;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_head;
  logic                  sel_tail;

  // Grant selection: locked owner only, or first head candidate after last_idx.
  always_comb begin
    cand     = valid_i & head_i;
    grant_o  = '0;
    gnt_idx  = '0;
    scan_idx = '0;
    found    = 1'b0;
    if (state == LOCKED) begin
      gnt_idx = lock_idx;
      if (valid_i[lock_idx]) grant_o[lock_idx] = 1'b1;
    end else begin
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        scan_idx = IW'((32'(last_idx) + 1 + i) % NUM_IN);
        if (!found && cand[scan_idx]) begin
          found   = 1'b1;
          gnt_idx = scan_idx;
        end
      end
      if (found) grant_o[gnt_idx] = 1'b1;
    end
    if (!rstn) grant_o = '0;
  end

  always_comb begin
    slot_free = !valid_o || ready_i;
    ready_o   = grant_o & {NUM_IN{slot_free}};
    xfer      = |(valid_i & ready_o);
    sel_head  = |(head_i & grant_o);
    sel_tail  = |(tail_i & grant_o);
    sel_data  = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (grant_o[k]) sel_data = sel_data | data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      lock_idx <= '0;
      last_idx <= IW'(NUM_IN - 1);
      valid_o  <= 1'b0;
      head_o   <= 1'b0;
      tail_o   <= 1'b0;
      data_o   <= '0;
    end else begin
      if (xfer) begin
        valid_o <= 1'b1;
        data_o  <= sel_data;
        head_o  <= sel_head;
        tail_o  <= sel_tail;
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end

      if (xfer) begin
        case (state)
          IDLE: begin
            if (sel_tail) begin
              last_idx <= gnt_idx;
            end else begin
              state    <= LOCKED;
              lock_idx <= gnt_idx;
            end
          end
          LOCKED: begin
            if (sel_tail) begin
              state    <= IDLE;
              last_idx <= lock_idx;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_arb_mux_n.sv
// Bench for arb_mux_n: vector table plus hand sequences for backpressure,
// reset mid-packet and round-robin wrap on an 8-channel instance.
module tb_arb_mux_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstn;
  logic [3:0]   valid_i, head_i, tail_i, ready_o, grant_o;
  logic [127:0] data_i;
  logic         valid_o, head_o, tail_o, ready_i;
  logic [31:0]  data_o;

  logic [7:0]   valid8, head8, tail8, ready8, grant8, data_o8;
  logic [63:0]  data8;
  logic         valid_o8, head_o8, tail_o8, rdy8;

  arb_mux_n #(.NUM_IN(4), .DATA_WIDTH(32)) dut (
    .clk(clk), .rstn(rstn), .valid_i(valid_i), .head_i(head_i), .tail_i(tail_i),
    .data_i(data_i), .ready_o(ready_o), .grant_o(grant_o), .valid_o(valid_o),
    .head_o(head_o), .tail_o(tail_o), .data_o(data_o), .ready_i(ready_i));

  arb_mux_n #(.NUM_IN(8), .DATA_WIDTH(8)) dut8 (
    .clk(clk), .rstn(rstn), .valid_i(valid8), .head_i(head8), .tail_i(tail8),
    .data_i(data8), .ready_o(ready8), .grant_o(grant8), .valid_o(valid_o8),
    .head_o(head_o8), .tail_o(tail_o8), .data_o(data_o8), .ready_i(rdy8));

  typedef struct packed {
    logic [3:0] v, h, t;
    logic       rdy;
    logic [3:0] eg, er;
    logic       evo;
  } vec_t;

  typedef struct packed {
    logic [31:0] d;
    logic        h, t;
  } flit_t;

  vec_t  tbl [0:15];
  flit_t sbq [$];
  int    cmp_cnt = 0;
  int    err_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] mkdata(input int r);
    logic [127:0] d;
    for (int k = 0; k < 4; k++) d[k*32 +: 32] = 32'hD000_0000 | (32'(r) << 8) | 32'(k);
    return d;
  endfunction

  // One cycle: drive, check combinational outputs, retire an expected output
  // transfer from the scoreboard, then record the expected input transfer.
  task automatic step(input logic [3:0] v, input logic [3:0] h, input logic [3:0] t,
                      input logic [127:0] d, input logic rdy, input logic [3:0] eg,
                      input logic [3:0] er, input logic evo, input string nm);
    flit_t f;
    @(posedge clk); #1;
    valid_i = v; head_i = h; tail_i = t; data_i = d; ready_i = rdy;
    @(negedge clk);
    chk({nm, "_grant"}, 64'(grant_o), 64'(eg));
    chk({nm, "_ready"}, 64'(ready_o), 64'(er));
    chk({nm, "_valid_o"}, 64'(valid_o), 64'(evo));
    if (evo && rdy) begin
      if (sbq.size() == 0) begin
        chk({nm, "_sb_underflow"}, 64'(1), 64'(0));
      end else begin
        f = sbq.pop_front();
        chk({nm, "_data_o"}, 64'(data_o), 64'(f.d));
        chk({nm, "_head_o"}, 64'(head_o), 64'(f.h));
        chk({nm, "_tail_o"}, 64'(tail_o), 64'(f.t));
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (er[k]) begin
        f.d = d[k*32 +: 32]; f.h = h[k]; f.t = t[k];
        sbq.push_back(f);
      end
    end
  endtask

  task automatic rst_cycle(input logic [3:0] v, input logic [127:0] d, input logic rdy,
                           input string nm);
    @(posedge clk); #1;
    rstn = 1'b0; valid_i = v; head_i = v; tail_i = 4'b0000; data_i = d; ready_i = rdy;
    @(negedge clk);
    chk({nm, "_grant"}, 64'(grant_o), 64'(0));
    chk({nm, "_ready"}, 64'(ready_o), 64'(0));
    sbq.delete();
    @(posedge clk); #1;
    chk({nm, "_out"}, {valid_o, head_o, tail_o, data_o}, 64'(0));
    chk({nm, "_valid_o8"}, 64'(valid_o8), 64'(0));
    rstn = 1'b1; valid_i = '0; head_i = '0; tail_i = '0; ready_i = 1'b1;
  endtask

  task automatic step8(input logic [7:0] v, input logic [7:0] eg, input logic evo,
                       input logic [7:0] ed, input string nm);
    @(posedge clk); #1;
    valid8 = v; head8 = v; tail8 = v;
    @(negedge clk);
    chk({nm, "_grant8"}, 64'(grant8), 64'(eg));
    chk({nm, "_ready8"}, 64'(ready8), 64'(eg));
    chk({nm, "_valid_o8"}, 64'(valid_o8), 64'(evo));
    if (evo) chk({nm, "_data_o8"}, 64'(data_o8), 64'(ed));
  endtask

  logic [127:0] dbp;

  initial begin
    rstn = 1'b0; valid_i = '0; head_i = '0; tail_i = '0; data_i = '0; ready_i = 1'b1;
    valid8 = '0; head8 = '0; tail8 = '0; rdy8 = 1'b1;
    for (int k = 0; k < 8; k++) data8[k*8 +: 8] = 8'h30 + 8'(k);

    //              v        h        t      rdy   eg       er      evo
    tbl[0]  = '{4'b1111, 4'b1111, 4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b0};
    tbl[1]  = '{4'b1110, 4'b1111, 4'b1111, 1'b1, 4'b0010, 4'b0010, 1'b1};
    tbl[2]  = '{4'b1100, 4'b1111, 4'b1111, 1'b1, 4'b0100, 4'b0100, 1'b1};
    tbl[3]  = '{4'b1000, 4'b1111, 4'b1111, 1'b1, 4'b1000, 4'b1000, 1'b1};
    tbl[4]  = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1};
    tbl[5]  = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0};
    tbl[6]  = '{4'b1000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0};
    tbl[7]  = '{4'b1000, 4'b0000, 4'b1000, 1'b1, 4'b0000, 4'b0000, 1'b0};
    tbl[8]  = '{4'b1000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0};
    tbl[9]  = '{4'b0110, 4'b0110, 4'b0100, 1'b1, 4'b0010, 4'b0010, 1'b0};
    tbl[10] = '{4'b0110, 4'b0110, 4'b0100, 1'b1, 4'b0010, 4'b0010, 1'b1};
    tbl[11] = '{4'b0100, 4'b0100, 4'b0100, 1'b1, 4'b0000, 4'b0000, 1'b1};
    tbl[12] = '{4'b0110, 4'b0100, 4'b0110, 1'b1, 4'b0010, 4'b0010, 1'b0};
    tbl[13] = '{4'b0100, 4'b0100, 4'b0100, 1'b1, 4'b0100, 4'b0100, 1'b1};
    tbl[14] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1};
    tbl[15] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0};

    rst_cycle(4'b1111, mkdata(99), 1'b1, "reset0");
    rst_cycle(4'b1111, mkdata(99), 1'b1, "reset1");

    for (int r = 0; r < 16; r++)
      step(tbl[r].v, tbl[r].h, tbl[r].t, mkdata(r), tbl[r].rdy, tbl[r].eg, tbl[r].er,
           tbl[r].evo, $sformatf("row%0d", r));

    // Backpressure: held flit stays stable, then drains with same-cycle refill.
    dbp = '0;
    dbp[31:0]  = 32'hA5A5A5A5;
    dbp[63:32] = 32'h12345678;
    step(4'b0001, 4'b0001, 4'b0001, dbp, 1'b0, 4'b0001, 4'b0001, 1'b0, "bp_load");
    for (int i = 0; i < 5; i++) begin
      step(4'b0010, 4'b0010, 4'b0010, dbp, 1'b0, 4'b0010, 4'b0000, 1'b1, "bp_hold");
      chk("bp_hold_data", 64'(data_o), 64'h0000_0000_A5A5_A5A5);
    end
    step(4'b0010, 4'b0010, 4'b0010, dbp, 1'b1, 4'b0010, 4'b0010, 1'b1, "bp_release");
    step(4'b0000, 4'b0000, 4'b0000, dbp, 1'b1, 4'b0000, 4'b0000, 1'b1, "bp_drain");
    step(4'b0000, 4'b0000, 4'b0000, dbp, 1'b1, 4'b0000, 4'b0000, 1'b0, "bp_empty");

    // Reset while locked on ch2 with its head still held in the output slot.
    step(4'b0100, 4'b0100, 4'b0000, mkdata(40), 1'b1, 4'b0100, 4'b0100, 1'b0, "lk_head");
    rst_cycle(4'b0101, mkdata(41), 1'b0, "lk_reset");
    step(4'b0101, 4'b0101, 4'b0101, mkdata(42), 1'b1, 4'b0001, 4'b0001, 1'b0, "post_rst0");
    step(4'b0100, 4'b0101, 4'b0101, mkdata(43), 1'b1, 4'b0100, 4'b0100, 1'b1, "post_rst1");
    step(4'b0000, 4'b0000, 4'b0000, mkdata(44), 1'b1, 4'b0000, 4'b0000, 1'b1, "post_rst2");
    step(4'b0000, 4'b0000, 4'b0000, mkdata(45), 1'b1, 4'b0000, 4'b0000, 1'b0, "post_rst3");
    chk("sb_empty", 64'(sbq.size()), 64'(0));

    // 8-channel wrap-around from last_idx=7.
    step8(8'h81, 8'h01, 1'b0, 8'h00, "w0");
    step8(8'h80, 8'h80, 1'b1, 8'h30, "w1");
    step8(8'h09, 8'h01, 1'b1, 8'h37, "w2");
    step8(8'h88, 8'h08, 1'b1, 8'h30, "w3");
    step8(8'h80, 8'h80, 1'b1, 8'h33, "w4");
    step8(8'h00, 8'h00, 1'b1, 8'h37, "w5");
    step8(8'h00, 8'h00, 1'b0, 8'h00, "w6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
